alu_arbiter: RTL and testbench

- Shares a single ALU instance between two requesters, e.g. the main pipeline (req0) and a branch/address unit (req1).
- Each cycle it selects at most one request by round-robin and drives the ALU operand/opcode inputs combinationally from that request.
- It captures ALUResult into a per-requester response register with a valid/ready handshake.
- It sits between the requesters and the ALU and owns all ALU input muxing.

---
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_arbiter: round-robin share of one ALU between two requesters          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_srca,
  input  logic [DATA_WIDTH-1:0]    req0_srcb,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic                     req0_imm,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_srca,
  input  logic [DATA_WIDTH-1:0]    req1_srcb,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  input  logic                     req1_imm,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  output logic                     alu_imm,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  output logic                     rsp0_valid,
  input  logic                     rsp0_ready,
  output logic [DATA_WIDTH-1:0]    rsp0_data,
  output logic                     rsp1_valid,
  input  logic                     rsp1_ready,
  output logic [DATA_WIDTH-1:0]    rsp1_data
);

  logic                  r_last_grant;
  logic                  r_rsp0_valid;
  logic                  r_rsp1_valid;
  logic [DATA_WIDTH-1:0] r_rsp0_data;
  logic [DATA_WIDTH-1:0] r_rsp1_data;

  logic w_elig0;
  logic w_elig1;
  logic w_grant0;
  logic w_grant1;

  // A slot being drained this cycle may be refilled in the same cycle.
  assign w_elig0  = reset & req0_valid & (~r_rsp0_valid | rsp0_ready);
  assign w_elig1  = reset & req1_valid & (~r_rsp1_valid | rsp1_ready);
  assign w_grant0 = w_elig0 & (~w_elig1 | r_last_grant);
  assign w_grant1 = w_elig1 & (~w_elig0 | ~r_last_grant);

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  always_comb begin
    alu_srca = '0;
    alu_srcb = '0;
    alu_op   = '0;
    alu_imm  = 1'b0;
    if (w_grant0) begin
      alu_srca = req0_srca;
      alu_srcb = req0_srcb;
      alu_op   = req0_op;
      alu_imm  = req0_imm;
    end else if (w_grant1) begin
      alu_srca = req1_srca;
      alu_srcb = req1_srcb;
      alu_op   = req1_op;
      alu_imm  = req1_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_grant <= 1'b1;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_data  <= '0;
      r_rsp1_data  <= '0;
    end else begin
      if (w_grant0) begin
        r_rsp0_valid <= 1'b1;
        r_rsp0_data  <= alu_result;
      end else if (rsp0_ready) begin
        r_rsp0_valid <= 1'b0;
      end

      if (w_grant1) begin
        r_rsp1_valid <= 1'b1;
        r_rsp1_data  <= alu_result;
      end else if (rsp1_ready) begin
        r_rsp1_valid <= 1'b0;
      end

      if (w_grant0) begin
        r_last_grant <= 1'b0;
      end else if (w_grant1) begin
        r_last_grant <= 1'b1;
      end
    end
  end

  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_data  = r_rsp0_data;
  assign rsp1_data  = r_rsp1_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_arbiter: directed self-checking bench for alu_arbiter, Rev 1.0     |
// +--------------------------------------------------------------------------+
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_imm;
  logic        req1_valid, req1_ready, req1_imm;
  logic [31:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] alu_srca, alu_srcb, alu_result;
  logic [3:0]  alu_op;
  logic        alu_imm;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic [31:0] w_opb;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_srca(req0_srca),
    .req0_srcb(req0_srcb), .req0_op(req0_op), .req0_imm(req0_imm),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_srca(req1_srca),
    .req1_srcb(req1_srcb), .req1_op(req1_op), .req1_imm(req1_imm),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op), .alu_imm(alu_imm),
    .alu_result(alu_result),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data)
  );

  // Small ALU model: 3=add, 4=sub, 7=shift left; immediates sign-extend bits [11:0].
  always_comb begin
    w_opb = alu_imm ? {{20{alu_srcb[11]}}, alu_srcb[11:0]} : alu_srcb;
    case (alu_op)
      4'd3:    alu_result = alu_srca + w_opb;
      4'd4:    alu_result = alu_srca - w_opb;
      4'd7:    alu_result = alu_srca << w_opb[4:0];
      default: alu_result = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic imm);
    req0_valid = v; req0_srca = a; req0_srcb = b; req0_op = op; req0_imm = imm;
  endtask

  task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic imm);
    req1_valid = v; req1_srca = a; req1_srcb = b; req1_op = op; req1_imm = imm;
  endtask

  task automatic drain();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set_req0(1'b1, 32'd5, 32'd7, 4'd3, 1'b0);
    set_req1(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    step();
    step();
    check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("rst_rsp0_data", rsp0_data, 32'd0);
    check("rst_rsp1_data", rsp1_data, 32'd0);
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_alu_srca", alu_srca, 32'd0);

    // Single request
    reset = 1'b1;
    #1;
    check("single_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("single_alu_srca", alu_srca, 32'd5);
    step();
    req0_valid = 1'b0;
    check("single_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("single_rsp0_data", rsp0_data, 32'd12);
    check("single_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("idle_alu_op", {28'd0, alu_op}, 32'd0);
    step();
    check("hold_rsp0_data", rsp0_data, 32'd12);
    drain();
    check("drained_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);

    // Contention after a fresh reset: strict alternation starting with req0
    reset = 1'b0;
    step();
    reset = 1'b1;
    set_req0(1'b1, 32'd3, 32'd4, 4'd3, 1'b0);
    set_req1(1'b1, 32'd10, 32'd4, 4'd4, 1'b0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("cont%0d_req0_ready", i), {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("cont%0d_req1_ready", i), {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
      if (i % 2 == 0) check($sformatf("cont%0d_rsp0_data", i), rsp0_data, 32'd7);
      else            check($sformatf("cont%0d_rsp1_data", i), rsp1_data, 32'd6);
    end
    drain();

    // Backpressure: stalled rsp1 must not block req0
    rsp1_ready = 1'b0;
    set_req1(1'b1, 32'd20, 32'd1, 4'd3, 1'b0);
    step();
    check("bp_rsp1_data", rsp1_data, 32'd21);
    set_req1(1'b1, 32'd9, 32'd9, 4'd3, 1'b0);
    set_req0(1'b1, 32'd5, 32'd7, 4'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d_req1_ready", i), {31'd0, req1_ready}, 32'd0);
      check($sformatf("bp%0d_req0_ready", i), {31'd0, req0_ready}, 32'd1);
      step();
      check($sformatf("bp%0d_rsp1_data", i), rsp1_data, 32'd21);
      check($sformatf("bp%0d_rsp1_valid", i), {31'd0, rsp1_valid}, 32'd1);
    end
    rsp1_ready = 1'b1;
    #1;
    check("bp_release_req1_ready", {31'd0, req1_ready}, 32'd1);
    step();
    check("bp_release_rsp1_data", rsp1_data, 32'd18);
    drain();
    drain();

    // Immediate pass-through, no sign extension in the arbiter
    set_req1(1'b1, 32'd1, 32'h0000_0FFF, 4'd3, 1'b1);
    #1;
    check("imm_alu_imm", {31'd0, alu_imm}, 32'd1);
    check("imm_alu_srcb", alu_srcb, 32'h0000_0FFF);
    step();
    check("imm_rsp1_data", rsp1_data, 32'd0);
    check("imm_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    drain();

    // Drain-and-refill in the same cycle
    rsp0_ready = 1'b0;
    set_req0(1'b1, 32'd5, 32'd7, 4'd3, 1'b0);
    step();
    check("refill_pre_data", rsp0_data, 32'd12);
    set_req0(1'b1, 32'd2, 32'd3, 4'd7, 1'b0);
    rsp0_ready = 1'b1;
    #1;
    check("refill_req0_ready", {31'd0, req0_ready}, 32'd1);
    step();
    check("refill_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("refill_rsp0_data", rsp0_data, 32'd16);
    drain();

    // Reset mid-operation
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set_req0(1'b1, 32'd5, 32'd7, 4'd3, 1'b0);
    set_req1(1'b1, 32'd20, 32'd1, 4'd3, 1'b0);
    step();
    step();
    check("mid_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("mid_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    reset = 1'b0;
    step();
    check("mid_rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("mid_rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("mid_rst_rsp0_data", rsp0_data, 32'd0);
    check("mid_rst_rsp1_data", rsp1_data, 32'd0);
    reset = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    check("post_rst_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("post_rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    step();
    check("post_rst_rsp0_data", rsp0_data, 32'd12);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
